// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame sequencer.
// Command byte layout: {WR, BURST, ADDR[5:0]}.
package spi_frame_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrData,
    StRdData,
    StDone
  } state_e;

  localparam int unsigned CMD_WR    = 7;
  localparam int unsigned CMD_BURST = 6;

  localparam logic [7:0] DONE_BYTE = 8'h00;
  localparam logic [7:0] ERR_BYTE  = 8'hFF;

  function automatic logic in_range(input int unsigned addr, input int unsigned num_regs);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/spi_frame_ctrl.sv
// SPI transaction sequencer: decodes command + data bytes of each chip-select frame
// into register-file reads and writes, with optional auto-incrementing bursts.
module spi_frame_ctrl
  import spi_frame_pkg::*;
#(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned NUM_REGS = 16,
  parameter logic [7:0]  DEV_ID   = 8'hA5
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              i_cs_n,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_rx_valid,
  output logic [7:0]        o_tx_byte,
  output logic [ADDR_W-1:0] o_reg_raddr,
  input  logic [7:0]        i_reg_rdata,
  output logic              o_reg_re,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [7:0]        o_reg_wdata,
  output logic              o_reg_we,
  output logic              o_frame_busy,
  output logic              o_addr_err
);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_burst, w_burst_nxt;
  logic [7:0]        r_tx_byte, w_tx_nxt;
  logic              r_reg_re, w_re_nxt;
  logic              r_reg_we, w_we_nxt;
  logic [ADDR_W-1:0] r_reg_addr, w_reg_addr_nxt;
  logic [7:0]        r_reg_wdata, w_wdata_nxt;
  logic              r_addr_err, w_err_nxt;

  logic              w_frame_rst_n;
  logic              w_rx;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [ADDR_W-1:0] w_raddr;

  // Deasserted chip select acts as an asynchronous abort of the frame logic only.
  assign w_frame_rst_n = rst_n & ~i_cs_n;
  assign w_rx          = i_rx_valid & ~i_cs_n;
  assign w_cmd_addr    = i_rx_byte[ADDR_W-1:0];
  assign w_addr_inc    = r_addr + ADDR_W'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_burst_nxt    = r_burst;
    w_tx_nxt       = r_tx_byte;
    w_re_nxt       = 1'b0;
    w_we_nxt       = 1'b0;
    w_reg_addr_nxt = r_reg_addr;
    w_wdata_nxt    = r_reg_wdata;
    w_err_nxt      = r_addr_err;
    w_raddr        = r_addr;

    unique case (r_state)
      StIdle: begin
        if (w_rx) begin
          w_addr_nxt  = w_cmd_addr;
          w_burst_nxt = i_rx_byte[CMD_BURST];
          if (i_rx_byte[CMD_WR]) begin
            w_state_nxt = StWrData;
          end else begin
            // Prefetch so the first data slot already carries the register value.
            w_state_nxt = StRdData;
            w_raddr     = w_cmd_addr;
            if (in_range(32'(w_cmd_addr), NUM_REGS)) begin
              w_tx_nxt = i_reg_rdata;
              w_re_nxt = 1'b1;
            end else begin
              w_tx_nxt  = ERR_BYTE;
              w_err_nxt = 1'b1;
            end
          end
        end
      end

      StWrData: begin
        if (w_rx) begin
          w_reg_addr_nxt = r_addr;
          w_wdata_nxt    = i_rx_byte;
          if (in_range(32'(r_addr), NUM_REGS)) begin
            w_we_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
          if (r_burst) begin
            w_addr_nxt = w_addr_inc;
          end else begin
            w_state_nxt = StDone;
            w_tx_nxt    = DONE_BYTE;
          end
        end
      end

      StRdData: begin
        if (w_rx) begin
          if (r_burst) begin
            w_addr_nxt = w_addr_inc;
            w_raddr    = w_addr_inc;
            if (in_range(32'(w_addr_inc), NUM_REGS)) begin
              w_tx_nxt = i_reg_rdata;
              w_re_nxt = 1'b1;
            end else begin
              w_tx_nxt  = ERR_BYTE;
              w_err_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = StDone;
            w_tx_nxt    = DONE_BYTE;
          end
        end
      end

      StDone: begin
        w_tx_nxt = DONE_BYTE;
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge w_frame_rst_n) begin
    if (!w_frame_rst_n) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_burst   <= 1'b0;
      r_tx_byte <= DEV_ID;
      r_reg_re  <= 1'b0;
      r_reg_we  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_burst   <= w_burst_nxt;
      r_tx_byte <= w_tx_nxt;
      r_reg_re  <= w_re_nxt;
      r_reg_we  <= w_we_nxt;
    end
  end

  // Error flag and write port survive a frame abort.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_addr_err  <= 1'b0;
    end else begin
      r_reg_addr  <= w_reg_addr_nxt;
      r_reg_wdata <= w_wdata_nxt;
      r_addr_err  <= w_err_nxt;
    end
  end

  assign o_tx_byte    = r_tx_byte;
  assign o_reg_raddr  = w_raddr;
  assign o_reg_re     = r_reg_re;
  assign o_reg_addr   = r_reg_addr;
  assign o_reg_wdata  = r_reg_wdata;
  assign o_reg_we     = r_reg_we;
  assign o_frame_busy = (r_state != StIdle);
  assign o_addr_err   = r_addr_err;

endmodule
